// File: rtl/ga_pkg.sv
// Shared definitions for the GA mutation stages: chromosome width, FSM states,
// LFSR constants and the segment-length clamp helper.
package ga_pkg;

   localparam int CHROM_W = 150;
   localparam int IDX_W   = 8;

   typedef logic [CHROM_W-1:0] chrom_t;

   typedef enum logic [1:0] {IDLE, DRAW, SWAP, DONE} state_e;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Limit hi so the segment [lo..hi] is at most max_seg bits long.
   function automatic logic [IDX_W-1:0] seg_clamp(input logic [IDX_W-1:0] lo,
                                                  input logic [IDX_W-1:0] hi,
                                                  input int max_seg);
      int lim;
      lim = int'(lo) + max_seg - 1;
      return (int'(hi) > lim) ? IDX_W'(lim) : hi;
   endfunction

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit right-shifting Galois LFSR with seed load (priority) and advance enable.
// A zero seed is replaced by the default seed so the register never locks up.
module ga_lfsr16
   import ga_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [15:0] i_seed,
   input  logic        i_advance,
   output logic [15:0] o_lfsr
);

   logic [15:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_load) begin
         r_lfsr <= (i_seed == 16'h0000) ? LFSR_SEED : i_seed;
      end else if (i_advance) begin
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
      end
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/inversion_sched.sv
// Inversion-mutation sequencer: accepts a parent, picks a segment (forced or PRNG),
// reverses it one bit-pair per cycle and hands back the mutant. Optional: INV_PROB_EN.
module inversion_sched #(
   parameter int           CHROM_W     = ga_pkg::CHROM_W,
   parameter int           MAX_SEG     = 150,
   parameter int           MAX_RETRY   = 8,
   parameter logic [7:0]   PROB_THRESH = 8'd64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seed_load,
   input  logic [15:0]        seed,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CHROM_W-1:0] parent,
   input  logic               force_en,
   input  logic [7:0]         force_lo,
   input  logic [7:0]         force_hi,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CHROM_W-1:0] mutant,
   output logic               skipped,
   output logic [7:0]         seg_lo,
   output logic [7:0]         seg_hi
);
   import ga_pkg::*;

   localparam int         RW   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [7:0] LAST = 8'(CHROM_W - 1);

   state_e             r_state, w_state_next;
   logic [CHROM_W-1:0] r_work;
   logic [7:0]         r_lo, r_hi, r_seg_lo, r_seg_hi;
   logic [RW-1:0]      r_retry;
   logic               r_skipped;
   logic [15:0]        w_lfsr;
   logic [7:0]         w_a, w_b, w_dlo, w_dhi;
   logic [7:0]         w_fa, w_fb, w_flo, w_fhi;
   logic               w_pair_ok;
`ifdef INV_PROB_EN
   logic               r_prob_chk;
`endif

   ga_lfsr16 u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (seed_load),
      .i_seed    (seed),
      .i_advance (r_state == DRAW),
      .o_lfsr    (w_lfsr)
   );

   assign w_a       = w_lfsr[7:0];
   assign w_b       = w_lfsr[15:8];
   assign w_pair_ok = (int'(w_a) < CHROM_W) && (int'(w_b) < CHROM_W) && (w_a != w_b);
   assign w_dlo     = (w_a < w_b) ? w_a : w_b;
   assign w_dhi     = seg_clamp(w_dlo, (w_a < w_b) ? w_b : w_a, MAX_SEG);

   // Forced indices: clamp into range, order them, then limit the span.
   assign w_fa  = (force_lo > LAST) ? LAST : force_lo;
   assign w_fb  = (force_hi > LAST) ? LAST : force_hi;
   assign w_flo = (w_fa < w_fb) ? w_fa : w_fb;
   assign w_fhi = seg_clamp(w_flo, (w_fa < w_fb) ? w_fb : w_fa, MAX_SEG);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = force_en ? SWAP : DRAW;
         end
         DRAW: begin
`ifdef INV_PROB_EN
            if (r_prob_chk) begin
               if (w_a >= PROB_THRESH) w_state_next = DONE;
            end else
`endif
            if (w_pair_ok)                        w_state_next = SWAP;
            else if (int'(r_retry) == MAX_RETRY - 1) w_state_next = DONE;
         end
         SWAP: begin
            // Done once this swap leaves lo >= hi, or if nothing is left to swap.
            if ((r_lo >= r_hi) || ((r_hi - r_lo) <= 8'd2)) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work    <= '0;
         r_lo      <= '0;
         r_hi      <= '0;
         r_seg_lo  <= '0;
         r_seg_hi  <= '0;
         r_retry   <= '0;
         r_skipped <= 1'b0;
`ifdef INV_PROB_EN
         r_prob_chk <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work    <= parent;
                  r_retry   <= '0;
                  r_skipped <= 1'b0;
                  if (force_en) begin
                     r_lo     <= w_flo;
                     r_hi     <= w_fhi;
                     r_seg_lo <= w_flo;
                     r_seg_hi <= w_fhi;
                  end
`ifdef INV_PROB_EN
                  r_prob_chk <= !force_en;
`endif
               end
            end
            DRAW: begin
`ifdef INV_PROB_EN
               if (r_prob_chk) begin
                  r_prob_chk <= 1'b0;
                  if (w_a >= PROB_THRESH) r_skipped <= 1'b1;
               end else
`endif
               if (w_pair_ok) begin
                  r_lo     <= w_dlo;
                  r_hi     <= w_dhi;
                  r_seg_lo <= w_dlo;
                  r_seg_hi <= w_dhi;
               end else begin
                  r_retry <= RW'(r_retry + 1'b1);
                  if (int'(r_retry) == MAX_RETRY - 1) r_skipped <= 1'b1;
               end
            end
            SWAP: begin
               if (r_lo < r_hi) begin
                  r_work[r_lo] <= r_work[r_hi];
                  r_work[r_hi] <= r_work[r_lo];
                  r_lo         <= r_lo + 8'd1;
                  r_hi         <= r_hi - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mutant  = r_work;
   assign skipped = r_skipped;
   assign seg_lo  = r_seg_lo;
   assign seg_hi  = r_seg_hi;

endmodule

// File: tb/tb_inversion_sched.sv
// Directed bench for inversion_sched: three instances (default, MAX_SEG=4, MAX_RETRY=1)
// share data inputs; each has its own in_valid/out_ready.
module tb_inversion_sched;
   import ga_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         seed_load;
   logic [15:0]  seed;
   logic [149:0] parent;
   logic         force_en;
   logic [7:0]   force_lo, force_hi;
   logic         in_valid  [3];
   logic         out_ready [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic [149:0] mutant    [3];
   logic         skipped   [3];
   logic [7:0]   seg_lo    [3];
   logic [7:0]   seg_hi    [3];

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   inversion_sched u_dut0 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .parent(parent),
      .force_en(force_en), .force_lo(force_lo), .force_hi(force_hi),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .mutant(mutant[0]),
      .skipped(skipped[0]), .seg_lo(seg_lo[0]), .seg_hi(seg_hi[0]));

   inversion_sched #(.MAX_SEG(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .parent(parent),
      .force_en(force_en), .force_lo(force_lo), .force_hi(force_hi),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .mutant(mutant[1]),
      .skipped(skipped[1]), .seg_lo(seg_lo[1]), .seg_hi(seg_hi[1]));

   inversion_sched #(.MAX_RETRY(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .parent(parent),
      .force_en(force_en), .force_lo(force_lo), .force_hi(force_hi),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .mutant(mutant[2]),
      .skipped(skipped[2]), .seg_lo(seg_lo[2]), .seg_hi(seg_hi[2]));

   task automatic check(input string tag, input logic [149:0] got, input logic [149:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [149:0] reverse_seg(input logic [149:0] p, input int lo, input int hi);
      logic [149:0] m;
      m = p;
      for (int i = lo; i <= hi; i++) m[i] = p[lo + hi - i];
      return m;
   endfunction

   // Reference draw for the default instance (CHROM_W=150, MAX_SEG=150, MAX_RETRY=8).
   task automatic model_draw(output int lo, output int hi, output logic skp);
      int a, b, retry;
      lo = 0; hi = 0; skp = 1'b0; retry = 0;
`ifdef INV_PROB_EN
      a = int'(m_lfsr[7:0]);
      m_lfsr = lfsr_step(m_lfsr);
      if (a >= 64) begin
         skp = 1'b1;
         return;
      end
`endif
      forever begin
         a = int'(m_lfsr[7:0]);
         b = int'(m_lfsr[15:8]);
         m_lfsr = lfsr_step(m_lfsr);
         if (a < 150 && b < 150 && a != b) begin
            lo = (a < b) ? a : b;
            hi = (a < b) ? b : a;
            return;
         end
         retry++;
         if (retry == 8) begin
            skp = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_out(input int d, output int cyc);
      cyc = 0;
      while (!out_valid[d] && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("out_valid_d%0d", d), 150'(out_valid[d]), 150'd1);
   endtask

   task automatic accept(input int d, input logic [149:0] p, input logic fe,
                         input logic [7:0] lo, input logic [7:0] hi);
      parent = p; force_en = fe; force_lo = lo; force_hi = hi;
      in_valid[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      force_en = 1'b0;
   endtask

   task automatic handshake(input int d);
      check($sformatf("in_ready_busy_d%0d", d), 150'(in_ready[d]), 150'd0);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      check($sformatf("out_valid_drop_d%0d", d), 150'(out_valid[d]), 150'd0);
      check($sformatf("in_ready_back_d%0d", d), 150'(in_ready[d]), 150'd1);
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed = s; seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
   endtask

   task automatic forced_case(input int d, input string name, input logic [149:0] p,
                              input logic [7:0] lo, input logic [7:0] hi,
                              input logic [149:0] exp_m, input int exp_lo, input int exp_hi,
                              input int exp_lat);
      int lat;
      accept(d, p, 1'b1, lo, hi);
      wait_out(d, lat);
      check({name, "_latency"}, 150'(lat), 150'(exp_lat));
      check({name, "_mutant"}, mutant[d], exp_m);
      check({name, "_seg_lo"}, 150'(seg_lo[d]), 150'(exp_lo));
      check({name, "_seg_hi"}, 150'(seg_hi[d]), 150'(exp_hi));
      check({name, "_skipped"}, 150'(skipped[d]), 150'd0);
      handshake(d);
   endtask

   initial begin
      logic [149:0] p;
      logic [159:0] rnd;
      logic         skp;
      int           lo, hi, lat;

      rst_n = 1'b0; seed_load = 1'b0; seed = '0; parent = '0;
      force_en = 1'b0; force_lo = '0; force_hi = '0;
      for (int i = 0; i < 3; i++) begin in_valid[i] = 1'b0; out_ready[i] = 1'b0; end
      #12;
      check("rst_in_ready",  150'(in_ready[0]),  150'd1);
      check("rst_out_valid", 150'(out_valid[0]), 150'd0);
      check("rst_skipped",   150'(skipped[0]),   150'd0);
      check("rst_mutant",    mutant[0],          150'd0);
      check("rst_seg_hi",    150'(seg_hi[0]),    150'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      forced_case(0, "fwd_3_6",  150'h58, 8'd3,  8'd6,  150'h68, 3, 6, 2);
      p = 150'h1234_5678_9ABC_DEF0;
      forced_case(0, "eq_10_10", p,       8'd10, 8'd10, p,       10, 10, 1);
      forced_case(0, "rev_6_3",  150'h58, 8'd6,  8'd3,  150'h68, 3, 6, 2);
      forced_case(0, "clamp_149", 150'h1, 8'd0, 8'd200, 150'h1 << 149, 0, 149, 75);
      forced_case(1, "maxseg4",  150'h1,  8'd0,  8'd200, 150'h8,  0, 3, 2);

      // Retry exhaustion: first draw has a = 0xFF, out of range.
      load_seed(16'h00FF);
      p = 150'hDEAD_BEEF_0000_1111;
      accept(2, p, 1'b0, 8'd0, 8'd0);
      wait_out(2, lat);
      check("retry_skipped", 150'(skipped[2]), 150'd1);
      check("retry_mutant",  mutant[2],        p);
      handshake(2);

      // PRNG draws with downstream backpressure.
      load_seed(16'h0001);
      m_lfsr = 16'h0001;
      for (int t = 0; t < 4; t++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
         p = rnd[149:0];
         accept(0, p, 1'b0, 8'd0, 8'd0);
         model_draw(lo, hi, skp);
         wait_out(0, lat);
         for (int c = 0; c < 5; c++) begin
            check($sformatf("prng%0d_hold%0d", t, c), mutant[0], skp ? p : reverse_seg(p, lo, hi));
            @(posedge clk); #1;
         end
         check($sformatf("prng%0d_skipped", t), 150'(skipped[0]), 150'(skp));
         if (!skp) begin
            check($sformatf("prng%0d_seg_lo", t), 150'(seg_lo[0]), 150'(lo));
            check($sformatf("prng%0d_seg_hi", t), 150'(seg_hi[0]), 150'(hi));
         end
         handshake(0);
      end

      // Asynchronous reset in the middle of a long swap sequence.
      accept(0, 150'h1, 1'b1, 8'd0, 8'd200);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 150'(out_valid[0]), 150'd0);
      check("arst_in_ready",  150'(in_ready[0]),  150'd1);
      check("arst_mutant",    mutant[0],          150'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      forced_case(0, "post_rst", 150'h58, 8'd3, 8'd6, 150'h68, 3, 6, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
